// File: rtl/mar_burst.sv
// mar_burst -- memory address register for the SAP datapath.
//
// Captures addresses from the shared bus and supports base+offset indexing,
// increment/decrement stepping and an autonomous burst sequencer that walks a
// run of consecutive addresses.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous, active-high reset
//   mar_write    load bus[ADDR_W-1:0] into the address register
//   base_write   load bus[ADDR_W-1:0] into the base register (any state)
//   mar_idx      load base + bus[ADDR_W-1:0]
//   mar_inc      step address up by one
//   mar_dec      step address down by one
//   burst_start  start burst: address bus[ADDR_W-1:0],
//                length bus[ADDR_W+CNT_W-1:ADDR_W]
//   burst_hold   stall the burst for this cycle
//   burst_abort  terminate the burst without a done pulse
//   bus          shared data bus
//   mar_out      registered address to RAM
//   burst_busy   high while the sequencer is in BURST
//   burst_done   registered one-cycle completion pulse
//   wrap         sticky address-wrap flag
module mar_burst #(
    parameter int                 BUS_W      = 16,
    parameter int                 ADDR_W     = 8,
    parameter int                 CNT_W      = 4,
    parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mar_write,
    input  logic              base_write,
    input  logic              mar_idx,
    input  logic              mar_inc,
    input  logic              mar_dec,
    input  logic              burst_start,
    input  logic              burst_hold,
    input  logic              burst_abort,
    input  logic [BUS_W-1:0]  bus,
    output logic [ADDR_W-1:0] mar_out,
    output logic              burst_busy,
    output logic              burst_done,
    output logic              wrap
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] mar_reg, mar_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic [CNT_W-1:0]  remaining_reg, remaining_next;
    logic              done_reg, done_next;
    logic              wrap_reg, wrap_next;

    logic [ADDR_W-1:0] bus_addr;
    logic [CNT_W-1:0]  burst_len;
    logic [ADDR_W-1:0] idx_sum;
    logic              idx_carry;
    logic              mar_all_ones;
    logic              mar_all_zero;

    assign bus_addr  = bus[ADDR_W-1:0];
    assign burst_len = bus[ADDR_W+CNT_W-1:ADDR_W];

    // Bus bits above the address and length fields carry nothing for this block.
    generate
        if (BUS_W > ADDR_W + CNT_W) begin : g_spare_bus
            logic unused_bus_bits;
            assign unused_bus_bits = ^bus[BUS_W-1:ADDR_W+CNT_W];
        end
    endgenerate

    // Extra bit on the sum exposes the carry that marks an indexing wrap.
    assign {idx_carry, idx_sum} = {1'b0, base_reg} + {1'b0, bus_addr};
    assign mar_all_ones         = (mar_reg == {ADDR_W{1'b1}});
    assign mar_all_zero         = (mar_reg == {ADDR_W{1'b0}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            mar_reg       <= RESET_ADDR;
            base_reg      <= '0;
            remaining_reg <= '0;
            done_reg      <= 1'b0;
            wrap_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mar_reg       <= mar_next;
            base_reg      <= base_next;
            remaining_reg <= remaining_next;
            done_reg      <= done_next;
            wrap_reg      <= wrap_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mar_next       = mar_reg;
        remaining_next = remaining_reg;
        done_next      = 1'b0;
        wrap_next      = wrap_reg;
        // The base register is outside the priority chain; mar_idx in the
        // same cycle still sees base_reg (the old value).
        base_next      = base_write ? bus_addr : base_reg;

        case (state_reg)
            IDLE: begin
                // A zero-length start is dropped entirely, letting lower
                // priority strobes in the same cycle take effect.
                if (burst_start && (burst_len != '0)) begin
                    mar_next       = bus_addr;
                    remaining_next = burst_len - CNT_W'(1);
                    wrap_next      = 1'b0;
                    if (burst_len == CNT_W'(1)) begin
                        done_next = 1'b1;
                    end else begin
                        state_next = BURST;
                    end
                end else if (mar_write) begin
                    mar_next  = bus_addr;
                    wrap_next = 1'b0;
                end else if (mar_idx) begin
                    mar_next  = idx_sum;
                    wrap_next = idx_carry;
                end else if (mar_inc && !mar_dec) begin
                    mar_next = mar_reg + ADDR_W'(1);
                    if (mar_all_ones) wrap_next = 1'b1;
                end else if (mar_dec && !mar_inc) begin
                    mar_next = mar_reg - ADDR_W'(1);
                    if (mar_all_zero) wrap_next = 1'b1;
                end
            end

            BURST: begin
                if (burst_abort) begin
                    state_next     = IDLE;
                    remaining_next = '0;
                end else if (!burst_hold) begin
                    mar_next       = mar_reg + ADDR_W'(1);
                    remaining_next = remaining_reg - CNT_W'(1);
                    if (mar_all_ones) wrap_next = 1'b1;
                    if (remaining_reg == CNT_W'(1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign mar_out    = mar_reg;
    assign burst_busy = (state_reg == BURST);
    assign burst_done = done_reg;
    assign wrap       = wrap_reg;

endmodule
